issue_scoreboard: RTL
=====================

// Module: issue_scoreboard
// PURPOSE
//  Issue-stage hazard controller between decode and execute. Holds one decoded
//  instruction, compares its source registers against a per-register pending-write
//  scoreboard, stalls on RAW/WAW hazards, and releases it to execute via valid/ready.
//  Writeback clears the pending bits. Read/write-register fields arrive pre-decoded.
// PARAMETERS
//  NUM_REGS  32  architectural register count (power of 2)
//  REG_W     5   register index width, log2(NUM_REGS)
// PORTS
//  clk             in   1         clock, rising edge
//  rst             in   1         asynchronous reset, active-high
//  dec_valid       in   1         decode presents an instruction
//  dec_ready       out  1         issue slot can accept this cycle
//  dec_instr       in   32        raw instruction word, passed through
//  dec_reads_0/1   in   1         source 0/1 is used
//  dec_read_reg_0/1 in  REG_W     source 0/1 index
//  dec_writes      in   1         instruction writes a destination
//  dec_write_reg   in   REG_W     destination index
//  iss_valid       out  1         held instruction is hazard-free, offered to execute
//  iss_ready       in   1         execute accepts
//  iss_instr       out  32        held instruction word
//  wb_valid        in   1         writeback completes this cycle
//  wb_reg          in   REG_W     register being written back
//  flush           in   1         discard held instruction (pending bits kept)
//  pending         out  NUM_REGS  scoreboard bits, bit i = write to reg i in flight
//  stalled         out  1         held instruction blocked by a hazard this cycle
// BEHAVIOUR
//  - Reset (async): hold_valid=0, pending=0, held fields=0; so iss_valid=0,
//    iss_instr=0, stalled=0, dec_ready=1. Reset mid-operation drops all in-flight state.
//  - States: EMPTY (hold_valid=0), HELD (hold_valid=1). EMPTY->HELD on dec_valid&dec_ready.
//    HELD->EMPTY on issue fire (iss_valid&iss_ready) with no new dec accept, or on flush.
//    HELD->HELD on fire with simultaneous accept (back-to-back, 1 instr/cycle).
//  - dec_ready = !flush & (!hold_valid | (iss_valid & iss_ready)); combinational.
//  - hazard = (r0 & pend[rr0]) | (r1 & pend[rr1]) | (w & pend[wr]); pend is the
//    effective scoreboard (see CONFIGURATION). iss_valid = hold_valid & !hazard & !flush.
//  - stalled = hold_valid & hazard & !flush.
//  - Latency: instruction accepted in cycle N -> iss_valid earliest in N+1.
//  - Scoreboard update at clock edge: on fire with w=1, set pending[wr]; on wb_valid,
//    clear pending[wb_reg]. Same register set and cleared same cycle -> set wins.
//    wb_valid to a non-pending register is ignored (no error).
//  - iss_ready low while iss_valid: hold contents and iss_valid stable until fire.
//  - flush has priority over dec_valid and fire: no accept, no issue, no pending set
//    that cycle; wb clears still applied.
//  - All NUM_REGS indices treated alike; no hardwired-zero register.
// CONFIGURATION
//  ISSUE_WB_BYPASS_EN defined: effective pend = pending & ~(wb_valid ? onehot(wb_reg) : 0);
//    an instruction stalled only on wb_reg issues in the same cycle as the writeback.
//  Undefined: effective pend = pending (registered); release one cycle after writeback.
// TESTING
//  1 Reset: assert rst mid-stream with pending!=0 -> pending=0, iss_valid=0, dec_ready=1
//    immediately, without a clock edge.
//  2 No hazard: dec writes r3 at N, iss_ready=1 -> iss_valid at N+1, pending[3]=1 at N+2.
//  3 RAW: pending[3]=1, dec reads r3 -> stalled=1, iss_valid=0; wb_valid,wb_reg=3 in cycle
//    M -> iss_valid at M+1 (bypass off) or at M (ISSUE_WB_BYPASS_EN).
//  4 WAW + set/clear collision: pending[5]=1, wb r5 and fire of new write r5 same cycle
//    -> pending[5]=1 after edge.
//  5 Backpressure: iss_ready=0 for 3 cycles -> iss_instr stable, dec_ready=0; iss_ready=1
//    with dec_valid -> fire and accept same cycle, next instr offered next cycle.
//  6 Flush: flush with HELD stalled instr -> EMPTY next cycle, pending unchanged, no issue.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Issue-stage bus: decode handshake, execute handshake, writeback and
// scoreboard status. The master side is the environment (decode, execute,
// writeback); the slave side is the issue_scoreboard itself.
interface issue_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = 5
);
    logic                dec_valid;
    logic                dec_ready;
    logic [31:0]         dec_instr;
    logic                dec_reads_0;
    logic                dec_reads_1;
    logic [REG_W-1:0]    dec_read_reg_0;
    logic [REG_W-1:0]    dec_read_reg_1;
    logic                dec_writes;
    logic [REG_W-1:0]    dec_write_reg;
    logic                iss_valid;
    logic                iss_ready;
    logic [31:0]         iss_instr;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_reg;
    logic                flush;
    logic [NUM_REGS-1:0] pending;
    logic                stalled;

    modport master (
        output dec_valid, dec_instr, dec_reads_0, dec_reads_1,
               dec_read_reg_0, dec_read_reg_1, dec_writes, dec_write_reg,
               iss_ready, wb_valid, wb_reg, flush,
        input  dec_ready, iss_valid, iss_instr, pending, stalled
    );

    modport slave (
        input  dec_valid, dec_instr, dec_reads_0, dec_reads_1,
               dec_read_reg_0, dec_read_reg_1, dec_writes, dec_write_reg,
               iss_ready, wb_valid, wb_reg, flush,
        output dec_ready, iss_valid, iss_instr, pending, stalled
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller: holds one decoded instruction, stalls it on
// RAW/WAW hazards against a per-register pending-write scoreboard and offers
// it to execute with a valid/ready handshake. Writeback clears pending bits.
// Optional feature macro: ISSUE_WB_BYPASS_EN -- a writeback in the current
// cycle masks its pending bit in the hazard check, so a dependent
// instruction issues in the same cycle as the writeback.
module issue_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = 5
) (
    input logic clk,
    input logic rst,
    issue_scoreboard_if.slave bus
);
    typedef enum logic {EMPTY, HELD} state_t;

    state_t              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic                r0_q, r0_d;
    logic                r1_q, r1_d;
    logic                w_q, w_d;
    logic [REG_W-1:0]    rr0_q, rr0_d;
    logic [REG_W-1:0]    rr1_q, rr1_d;
    logic [REG_W-1:0]    wr_q, wr_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    logic [NUM_REGS-1:0] wb_onehot;
    logic [NUM_REGS-1:0] set_onehot;
    logic [NUM_REGS-1:0] pend_eff;
    logic                hold_valid;
    logic                hazard;
    logic                iss_valid;
    logic                fire;
    logic                dec_ready;
    logic                accept;

    // Hazard detection and handshake qualification against the effective scoreboard.
    always_comb begin
        wb_onehot  = bus.wb_valid ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << bus.wb_reg) : '0;
        set_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << wr_q;
`ifdef ISSUE_WB_BYPASS_EN
        pend_eff   = pending_q & ~wb_onehot;
`else
        pend_eff   = pending_q;
`endif
        hold_valid = (state_q == HELD);
        hazard     = (r0_q & pend_eff[rr0_q]) |
                     (r1_q & pend_eff[rr1_q]) |
                     (w_q  & pend_eff[wr_q]);
        iss_valid  = hold_valid & ~hazard & ~bus.flush;
        fire       = iss_valid & bus.iss_ready;
        dec_ready  = ~bus.flush & (~hold_valid | fire);
        accept     = bus.dec_valid & dec_ready;
    end

    // Next state: flush empties the slot, an accept (re)loads it, a lone fire empties it.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        r0_d    = r0_q;
        rr0_d   = rr0_q;
        r1_d    = r1_q;
        rr1_d   = rr1_q;
        w_d     = w_q;
        wr_d    = wr_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = HELD;
            instr_d = bus.dec_instr;
            r0_d    = bus.dec_reads_0;
            rr0_d   = bus.dec_read_reg_0;
            r1_d    = bus.dec_reads_1;
            rr1_d   = bus.dec_read_reg_1;
            w_d     = bus.dec_writes;
            wr_d    = bus.dec_write_reg;
        end else if (fire) begin
            state_d = EMPTY;
        end
        // Clear first, then set, so an issuing write wins over a same-cycle writeback.
        pending_d = (pending_q & ~wb_onehot) | ((fire & w_q) ? set_onehot : '0);
    end

    // State, held instruction and scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            instr_q   <= '0;
            r0_q      <= 1'b0;
            rr0_q     <= '0;
            r1_q      <= 1'b0;
            rr1_q     <= '0;
            w_q       <= 1'b0;
            wr_q      <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            r0_q      <= r0_d;
            rr0_q     <= rr0_d;
            r1_q      <= r1_d;
            rr1_q     <= rr1_d;
            w_q       <= w_d;
            wr_q      <= wr_d;
            pending_q <= pending_d;
        end
    end

    assign bus.dec_ready = dec_ready;
    assign bus.iss_valid = iss_valid;
    assign bus.iss_instr = instr_q;
    assign bus.pending   = pending_q;
    assign bus.stalled   = hold_valid & hazard & ~bus.flush;
endmodule
